// File: rtl/p1v_clk_pkg.sv
// -----------------------------------------------------------------------------
// p1v_clk_pkg
//    Shared definitions for the Propeller clock/reset control stage:
//    timing constants, cfg bit positions, the CLKSEL encoding, the
//    reset-sequencer state type and the divisor / source-requirement lookups.
// -----------------------------------------------------------------------------
package p1v_clk_pkg;

   // Master (clk_pll) cycle counts
   localparam int DIV_RCFAST = 16;     // master cycles per cog cycle, RCFAST
   localparam int DIV_RCSLOW = 4096;   // master cycles per cog cycle, RCSLOW
   localparam int OSC_WAIT   = 1024;   // OSCENA rise to osc_ok
   localparam int PLL_WAIT   = 256;    // PLLENA & osc_ok to pll_ok
   localparam int RES_HOLD   = 64;     // inp_res hold after any reset cause

   // Divider counter width: enough for the largest divisor minus one
   localparam int DIV_W = $clog2(DIV_RCSLOW);

   // cfg bit positions (as written by CLKSET)
   localparam int CFG_RESET    = 7;
   localparam int CFG_PLLENA   = 6;
   localparam int CFG_OSCENA   = 5;
   localparam int CFG_OSCM_MSB = 4;
   localparam int CFG_OSCM_LSB = 3;
   localparam int CFG_SEL_MSB  = 2;
   localparam int CFG_SEL_LSB  = 0;

   typedef enum logic [2:0] {
      SEL_RCFAST = 3'd0,
      SEL_RCSLOW = 3'd1,
      SEL_XINPUT = 3'd2,
      SEL_XTAL1  = 3'd3,
      SEL_XTAL2  = 3'd4,
      SEL_XTAL4  = 3'd5,
      SEL_XTAL8  = 3'd6,
      SEL_XTAL16 = 3'd7
   } clk_sel_e;

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_RUN   = 2'd1,
      ST_SWRES = 2'd2
   } state_e;

   // Terminal value of the divider for a source: the strobe fires when
   // div_cnt equals this. XTAL16 returns 0, so the strobe is constant.
   function automatic logic [DIV_W-1:0] div_last(input clk_sel_e sel);
      case (sel)
         SEL_RCFAST: div_last = DIV_W'(DIV_RCFAST - 1);
         SEL_RCSLOW: div_last = DIV_W'(DIV_RCSLOW - 1);
         SEL_XINPUT: div_last = DIV_W'(15);
         SEL_XTAL1:  div_last = DIV_W'(15);
         SEL_XTAL2:  div_last = DIV_W'(7);
         SEL_XTAL4:  div_last = DIV_W'(3);
         SEL_XTAL8:  div_last = DIV_W'(1);
         default:    div_last = '0;
      endcase
   endfunction

   // True when the clock sources a selection depends on are usable.
   function automatic logic sel_allowed(input clk_sel_e sel,
                                        input logic     osc,
                                        input logic     pll);
      case (sel)
         SEL_RCFAST, SEL_RCSLOW: sel_allowed = 1'b1;
         SEL_XINPUT, SEL_XTAL1:  sel_allowed = osc;
         default:                sel_allowed = osc & pll;
      endcase
   endfunction

endpackage

// File: rtl/stab_cnt.sv
// -----------------------------------------------------------------------------
// stab_cnt
//    Enable-gated saturating counter used to time oscillator start-up and
//    PLL lock. Counts master cycles while en is high, stops at WAIT and
//    reports done from then on. Dropping en clears the count (and so done)
//    on the next edge.
//
//    Ports
//       clk_pll  in   master clock
//       nres     in   asynchronous active-low reset
//       en       in   count enable; low clears the counter
//       done     out  counter has reached WAIT
// -----------------------------------------------------------------------------
module stab_cnt #(
   parameter int WAIT = 1024
) (
   input  logic clk_pll,
   input  logic nres,
   input  logic en,
   output logic done
);

   localparam int                CNT_W   = $clog2(WAIT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WAIT);

   logic [CNT_W-1:0] cnt;

   // NOTE: clocked state is written with <= so every flop samples the values
   // from before the edge, independent of process ordering.
   always_ff @(posedge clk_pll or negedge nres) begin
      if (!nres) begin
         cnt <= '0;
      end else if (!en) begin
         cnt <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign done = (cnt == CNT_MAX);

endmodule

// File: rtl/clk_ctl.sv
// -----------------------------------------------------------------------------
// clk_ctl
//    Clock/reset control stage in front of the Propeller core. Produces the
//    cog-clock enable strobe for the external clock gate, sequences the core
//    reset request, waits for oscillator/PLL stabilisation and switches the
//    clock source only on period boundaries.
//
//    Ports
//       clk_pll  in   master clock (16x rate), all flops on its rising edge
//       nres     in   asynchronous active-low reset
//       cfg      in   [7] RESET [6] PLLENA [5] OSCENA [4:3] OSCM [2:0] CLKSEL
//       ena_cog  out  one-master-cycle strobe per cog clock period
//       inp_res  out  active-high reset request to the core
//       cur_sel  out  CLKSEL currently in effect
//       osc_ok   out  oscillator stable
//       pll_ok   out  PLL locked
//       sel_err  out  sticky: a requested CLKSEL was refused
// -----------------------------------------------------------------------------
module clk_ctl
   import p1v_clk_pkg::*;
(
   input  logic       clk_pll,
   input  logic       nres,
   input  logic [7:0] cfg,
   output logic       ena_cog,
   output logic       inp_res,
   output logic [2:0] cur_sel,
   output logic       osc_ok,
   output logic       pll_ok,
   output logic       sel_err
);

   localparam int RES_W = $clog2(RES_HOLD);

   state_e            state;
   state_e            state_nxt;
   logic [RES_W-1:0]  res_cnt;
   logic              res_done;
   logic              force_rcfast;

   clk_sel_e          sel_q;
   clk_sel_e          sel_nxt;
   clk_sel_e          sel_req;
   logic [DIV_W-1:0]  div_cnt;
   logic [DIV_W-1:0]  div_nxt;
   logic              err_q;
   logic              err_nxt;

   logic              pll_en;
   logic              osc_hold;
   logic              pll_hold;
   logic              src_lost;
   logic              sel_pend;
   logic              unused_oscm;

   // OSCM is consumed by the pad block, not here.
   assign unused_oscm = ^cfg[CFG_OSCM_MSB:CFG_OSCM_LSB];

   // ---------------------------------------------------------------------
   // Stabilisation timers
   // ---------------------------------------------------------------------
   assign pll_en = cfg[CFG_PLLENA] & osc_ok;

   stab_cnt #(.WAIT(OSC_WAIT)) u_osc_cnt (
      .clk_pll (clk_pll),
      .nres    (nres),
      .en      (cfg[CFG_OSCENA]),
      .done    (osc_ok)
   );

   stab_cnt #(.WAIT(PLL_WAIT)) u_pll_cnt (
      .clk_pll (clk_pll),
      .nres    (nres),
      .en      (pll_en),
      .done    (pll_ok)
   );

   // A flag that is high now but whose enable is low will clear on this
   // edge; the *_hold terms let the selector react on that same edge.
   assign osc_hold = osc_ok & cfg[CFG_OSCENA];
   assign pll_hold = pll_ok & pll_en;

   // ---------------------------------------------------------------------
   // Reset sequencer: state register / next state / outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_pll or negedge nres) begin
      if (!nres) begin
         state <= ST_HOLD;
      end else begin
         state <= state_nxt;
      end
   end

   assign res_done = (res_cnt == RES_W'(RES_HOLD - 1));

   // NOTE: each combinational output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_HOLD:  if (res_done)        state_nxt = ST_RUN;
         ST_RUN:   if (cfg[CFG_RESET])  state_nxt = ST_SWRES;
         ST_SWRES: if (!cfg[CFG_RESET]) state_nxt = ST_HOLD;
         default:                       state_nxt = ST_HOLD;
      endcase
   end

   // RESET seen in RUN takes the clock back to RCFAST on the same edge that
   // enters SWRES, ahead of any loss-of-source or pending selection.
   always_comb begin
      inp_res      = 1'b1;
      force_rcfast = 1'b0;
      case (state)
         ST_RUN: begin
            inp_res      = 1'b0;
            force_rcfast = cfg[CFG_RESET];
         end
         ST_SWRES: force_rcfast = 1'b1;
         default: ;
      endcase
   end

   // Counts only in HOLD and wraps to 0 on the cycle HOLD exits, so every
   // entry to HOLD starts a full RES_HOLD stretch.
   always_ff @(posedge clk_pll or negedge nres) begin
      if (!nres) begin
         res_cnt <= '0;
      end else if (state == ST_HOLD && !res_done) begin
         res_cnt <= res_cnt + 1'b1;
      end else begin
         res_cnt <= '0;
      end
   end

   // ---------------------------------------------------------------------
   // Divider and source selection
   // ---------------------------------------------------------------------
   assign ena_cog  = (div_cnt == div_last(sel_q));
   assign sel_req  = clk_sel_e'(cfg[CFG_SEL_MSB:CFG_SEL_LSB]);
   assign src_lost = !sel_allowed(sel_q, osc_hold, pll_hold);
   // Changes are only looked at on the last cycle of a period, so the old
   // period always completes and the new one starts from div_cnt = 0.
   assign sel_pend = ena_cog && (sel_req != sel_q);

   always_comb begin
      sel_nxt = sel_q;
      div_nxt = ena_cog ? '0 : div_cnt + 1'b1;
      err_nxt = err_q;
      if (force_rcfast) begin
         if (sel_q != SEL_RCFAST) begin
            sel_nxt = SEL_RCFAST;
            div_nxt = '0;
         end
      end else if (src_lost) begin
         // The one switch that does not wait for a period boundary.
         sel_nxt = SEL_RCFAST;
         div_nxt = '0;
      end else if (sel_pend) begin
         if (sel_allowed(sel_req, osc_hold, pll_hold)) begin
            sel_nxt = sel_req;
            err_nxt = 1'b0;
         end else begin
            err_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_pll or negedge nres) begin
      if (!nres) begin
         sel_q   <= SEL_RCFAST;
         div_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         sel_q   <= sel_nxt;
         div_cnt <= div_nxt;
         err_q   <= err_nxt;
      end
   end

   assign cur_sel = sel_q;
   assign sel_err = err_q;

endmodule

// File: tb/tb_clk_ctl.sv
// -----------------------------------------------------------------------------
// tb_clk_ctl
//    Self-checking bench for clk_ctl. Expected strobe spacings are queued as
//    stimulus is applied and compared as ena_cog strobes appear; other
//    checks are made inline in each scenario task.
// -----------------------------------------------------------------------------
module tb_clk_ctl;

   localparam int OSC_WAIT = 1024;
   localparam int PLL_WAIT = 256;
   localparam int RES_HOLD = 64;

   logic       clk_pll = 1'b0;
   logic       nres    = 1'b0;
   logic [7:0] cfg     = 8'h00;
   logic       ena_cog;
   logic       inp_res;
   logic [2:0] cur_sel;
   logic       osc_ok;
   logic       pll_ok;
   logic       sel_err;

   int n_checks    = 0;
   int n_fail      = 0;
   int cyc         = 0;
   int last_strobe = -1;
   int sb_q[$];

   clk_ctl dut (
      .clk_pll (clk_pll),
      .nres    (nres),
      .cfg     (cfg),
      .ena_cog (ena_cog),
      .inp_res (inp_res),
      .cur_sel (cur_sel),
      .osc_ok  (osc_ok),
      .pll_ok  (pll_ok),
      .sel_err (sel_err)
   );

   always #5 clk_pll = ~clk_pll;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance one master cycle and sample 1 time unit after the edge. A strobe
   // pops the next expected spacing from the scoreboard, if any is queued.
   task automatic tick();
      int exp_gap;
      @(posedge clk_pll);
      #1;
      cyc++;
      if (ena_cog === 1'b1) begin
         if (sb_q.size() > 0) begin
            exp_gap = sb_q.pop_front();
            n_checks++;
            if ((cyc - last_strobe) !== exp_gap) begin
               n_fail++;
               $display("FAIL strobe_gap: at cycle %0d gap %0d, expected %0d", cyc, cyc - last_strobe, exp_gap);
            end
         end
         last_strobe = cyc;
      end
   endtask

   task automatic drain(input int budget, input string tag);
      int n = 0;
      while (sb_q.size() > 0 && n < budget) begin
         tick();
         n++;
      end
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d strobes still pending after %0d cycles", tag, sb_q.size(), n);
         sb_q.delete();
      end
   endtask

   task automatic wait_sel(input logic [2:0] sel, input int budget, input string tag);
      int n = 0;
      while (cur_sel !== sel && n < budget) begin
         tick();
         n++;
      end
      n_checks++;
      if (cur_sel !== sel) begin
         n_fail++;
         $display("FAIL %s_wait_sel: cur_sel %0d, expected %0d within %0d cycles", tag, cur_sel, sel, budget);
      end
   endtask

   task automatic release_reset();
      nres        = 1'b1;
      cyc         = 0;
      last_strobe = -1;
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      int hi = 0;
      int bad = 0;
      cfg = 8'h6F;   // reset must win over a live configuration
      repeat (3) tick();
      n_checks++; if (ena_cog !== 1'b0) begin n_fail++; $display("FAIL reset_ena_cog: got %b expected 0", ena_cog); end
      n_checks++; if (inp_res !== 1'b1) begin n_fail++; $display("FAIL reset_inp_res: got %b expected 1", inp_res); end
      n_checks++; if (cur_sel !== 3'd0) begin n_fail++; $display("FAIL reset_cur_sel: got %0d expected 0", cur_sel); end
      n_checks++; if (osc_ok !== 1'b0)  begin n_fail++; $display("FAIL reset_osc_ok: got %b expected 0", osc_ok); end
      n_checks++; if (pll_ok !== 1'b0)  begin n_fail++; $display("FAIL reset_pll_ok: got %b expected 0", pll_ok); end
      n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err: got %b expected 0", sel_err); end
      cfg = 8'h00;
      release_reset();
      repeat (6) sb_q.push_back(16);
      for (int k = 0; k < 100; k++) begin
         if (k > 0) tick();
         if (inp_res === 1'b1) hi++;
         if (inp_res !== (cyc < RES_HOLD)) bad++;
      end
      n_checks++; if (hi !== RES_HOLD) begin n_fail++; $display("FAIL reset_hold_len: got %0d cycles expected %0d", hi, RES_HOLD); end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL reset_hold_shape: %0d cycles wrong, expected 0", bad); end
      n_checks++; if (cur_sel !== 3'd0) begin n_fail++; $display("FAIL reset_run_sel: got %0d expected 0", cur_sel); end
      drain(10, "reset");
   endtask

   // ---------------------------------------------------------------------
   task automatic test_osc_select();
      int n = 0;
      int bad_sel = 0;
      int bad_err = 0;
      logic seen = 1'b0;
      cfg = 8'h22;   // OSCENA + XINPUT
      while (osc_ok !== 1'b1 && n < OSC_WAIT + 50) begin
         tick();
         n++;
         if (cur_sel !== 3'd0) bad_sel++;
         if (seen && sel_err !== 1'b1) bad_err++;
         if (ena_cog === 1'b1) seen = 1'b1;
      end
      n_checks++; if (n !== OSC_WAIT) begin n_fail++; $display("FAIL osc_wait: osc_ok after %0d cycles expected %0d", n, OSC_WAIT); end
      n_checks++; if (bad_sel !== 0) begin n_fail++; $display("FAIL osc_sel_held: %0d cycles with cur_sel != 0, expected 0", bad_sel); end
      n_checks++; if (bad_err !== 0) begin n_fail++; $display("FAIL osc_sel_err: %0d cycles without sel_err after refusal, expected 0", bad_err); end
      n_checks++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL osc_err_at_ok: got %b expected 1", sel_err); end
      repeat (3) sb_q.push_back(16);
      wait_sel(3'd2, 20, "osc");
      n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL osc_err_clear: got %b expected 0", sel_err); end
      drain(60, "osc");
   endtask

   // ---------------------------------------------------------------------
   // Starts on an XINPUT strobe cycle; PLL_WAIT is a multiple of 16, so
   // pll_ok also arrives in a strobe cycle and is accepted on that edge.
   task automatic test_loss_of_source();
      int n = 0;
      int bad = 0;
      cfg = 8'h65;   // PLLENA + OSCENA + XTAL4
      while (pll_ok !== 1'b1 && n < PLL_WAIT + 50) begin
         tick();
         n++;
         if (cur_sel !== 3'd2) bad++;
      end
      n_checks++; if (n !== PLL_WAIT) begin n_fail++; $display("FAIL pll_wait: pll_ok after %0d cycles expected %0d", n, PLL_WAIT); end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL pll_sel_held: %0d cycles with cur_sel != 2, expected 0", bad); end
      n_checks++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL pll_sel_err: got %b expected 1", sel_err); end
      repeat (3) sb_q.push_back(4);
      tick();
      n_checks++; if (cur_sel !== 3'd5) begin n_fail++; $display("FAIL xtal4_sel: got %0d expected 5", cur_sel); end
      n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL xtal4_err: got %b expected 0", sel_err); end
      drain(20, "xtal4");
      tick();
      tick();
      cfg = 8'h25;   // drop PLLENA mid-period
      tick();
      n_checks++; if (pll_ok !== 1'b0)  begin n_fail++; $display("FAIL loss_pll_ok: got %b expected 0", pll_ok); end
      n_checks++; if (cur_sel !== 3'd0) begin n_fail++; $display("FAIL loss_cur_sel: got %0d expected 0", cur_sel); end
      n_checks++; if (osc_ok !== 1'b1)  begin n_fail++; $display("FAIL loss_osc_ok: got %b expected 1", osc_ok); end
      n = 1;
      while (ena_cog !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      n_checks++; if (n !== 16) begin n_fail++; $display("FAIL loss_next_strobe: strobe in cycle %0d expected 16", n); end
      tick();
      n_checks++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL loss_refuse: got %b expected 1", sel_err); end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_rcslow_switch();
      cfg = 8'h01;   // RCSLOW, oscillator off
      wait_sel(3'd1, 20, "rcslow");
      n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL rcslow_err: got %b expected 0", sel_err); end
      n_checks++; if (osc_ok !== 1'b0)  begin n_fail++; $display("FAIL rcslow_osc_off: got %b expected 0", osc_ok); end
      sb_q.push_back(4096);
      repeat (3) sb_q.push_back(16);
      repeat (2000) tick();
      cfg = 8'h00;   // request RCFAST with div_cnt at 2000
      drain(4200, "rcslow");
      n_checks++; if (cur_sel !== 3'd0) begin n_fail++; $display("FAIL rcslow_back: got %0d expected 0", cur_sel); end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_swres();
      int hi = 0;
      cfg = 8'h01;
      wait_sel(3'd1, 20, "swres");
      n_checks++; if (inp_res !== 1'b0) begin n_fail++; $display("FAIL swres_pre: got %b expected 0", inp_res); end
      cfg = 8'h81;
      tick();
      n_checks++; if (inp_res !== 1'b1) begin n_fail++; $display("FAIL swres_rise: got %b expected 1", inp_res); end
      n_checks++; if (cur_sel !== 3'd0) begin n_fail++; $display("FAIL swres_sel: got %0d expected 0", cur_sel); end
      tick();
      tick();
      cfg = 8'h00;
      tick();
      while (inp_res === 1'b1 && hi < 200) begin
         hi++;
         tick();
      end
      n_checks++; if (hi !== RES_HOLD) begin n_fail++; $display("FAIL swres_hold: high %0d cycles after clear, expected %0d", hi, RES_HOLD); end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_xtal16_from_reset();
      int osc_cyc = -1;
      int pll_cyc = -1;
      int exp_sel = OSC_WAIT + PLL_WAIT;
      int low = 0;
      cfg = 8'h01;
      wait_sel(3'd1, 20, "midres");
      #2;
      nres = 1'b0;
      cfg  = 8'h6F;   // PLLENA + OSCENA + XTAL16
      #1;
      n_checks++; if (cur_sel !== 3'd0) begin n_fail++; $display("FAIL midres_sel: got %0d expected 0", cur_sel); end
      n_checks++; if (inp_res !== 1'b1) begin n_fail++; $display("FAIL midres_inp_res: got %b expected 1", inp_res); end
      n_checks++; if (ena_cog !== 1'b0) begin n_fail++; $display("FAIL midres_ena: got %b expected 0", ena_cog); end
      tick();
      release_reset();
      while (exp_sel % 16 != 15) exp_sel++;
      exp_sel++;
      while (cur_sel !== 3'd7 && cyc < 1400) begin
         tick();
         if (osc_ok === 1'b1 && osc_cyc < 0) osc_cyc = cyc;
         if (pll_ok === 1'b1 && pll_cyc < 0) pll_cyc = cyc;
      end
      n_checks++; if (osc_cyc !== OSC_WAIT) begin n_fail++; $display("FAIL x16_osc: osc_ok at %0d expected %0d", osc_cyc, OSC_WAIT); end
      n_checks++; if (pll_cyc !== OSC_WAIT + PLL_WAIT) begin n_fail++; $display("FAIL x16_pll: pll_ok at %0d expected %0d", pll_cyc, OSC_WAIT + PLL_WAIT); end
      n_checks++; if (cyc !== exp_sel) begin n_fail++; $display("FAIL x16_sel_time: cur_sel 7 at %0d expected %0d", cyc, exp_sel); end
      n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL x16_err: got %b expected 0", sel_err); end
      repeat (8) sb_q.push_back(1);
      drain(20, "x16");
      for (int k = 0; k < 20; k++) begin
         tick();
         if (ena_cog !== 1'b1) low++;
      end
      n_checks++; if (low !== 0) begin n_fail++; $display("FAIL x16_constant: %0d cycles without strobe, expected 0", low); end
   endtask

   initial begin
      test_reset();
      test_osc_select();
      test_loss_of_source();
      test_rcslow_switch();
      test_swres();
      test_xtal16_from_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_ctl.md
Name: clk_ctl

Overview:
- Clock/reset control stage directly upstream of the Propeller core top level.
- Consumes the core's 8-bit `cfg` (written by CLKSET) and produces the cog-clock enable strobe and the `inp_res` reset request that feed the core.
- Runs on the fastest clock (`clk_pll`, the 16x rate). The cog clock is derived by an external clock gate driven from `ena_cog`.
- Enforces oscillator/PLL stabilisation waits, glitch-free divisor switching and reset stretching.

Parameters:
- DIV_RCFAST, 16: master cycles per cog cycle in RCFAST mode.
- DIV_RCSLOW, 4096: master cycles per cog cycle in RCSLOW mode.
- OSC_WAIT, 1024: master cycles from OSCENA rise to `osc_ok`.
- PLL_WAIT, 256: master cycles from (PLLENA and `osc_ok`) to `pll_ok`.
- RES_HOLD, 64: master cycles `inp_res` is held after any reset cause.

Ports:
- clk_pll  in  1  master clock, 16x-capable; all flops on its rising edge.
- nres  in  1  reset, asynchronous, active-low.
- cfg  in  8  clock config from core: [7] RESET, [6] PLLENA, [5] OSCENA, [4:3] OSCM (unused here, passed to the pad block), [2:0] CLKSEL.
- ena_cog  out  1  one-master-cycle strobe per cog clock period.
- inp_res  out  1  active-high reset request to core.
- cur_sel  out  3  CLKSEL currently in effect.
- osc_ok  out  1  oscillator stable.
- pll_ok  out  1  PLL locked.
- sel_err  out  1  sticky: a requested CLKSEL was refused; clears on the next accepted change or on reset.

Behaviour:
- Reset values (`nres` low): `ena_cog`=0, `inp_res`=1, `cur_sel`=0, `osc_ok`=0, `pll_ok`=0, `sel_err`=0, all counters 0, FSM=HOLD.
- FSM states: HOLD, RUN, SWRES.
  - HOLD: `res_cnt` counts master cycles. When `res_cnt`=RES_HOLD-1, go to RUN and drive `inp_res`=0 on the next cycle.
  - RUN: `inp_res`=0. If `cfg[7]`=1, go to SWRES.
  - SWRES: `inp_res`=1, `res_cnt` cleared, `cur_sel` forced to 0. When `cfg[7]` has returned to 0 (the core clears `cfg` under its own reset), go to HOLD.
- `ena_cog` runs in every state, so the core sees clock edges while held in reset.
- Divider: 12-bit `div_cnt`. `ena_cog`=1 in the cycle where `div_cnt`=div-1; `div_cnt` then wraps to 0, otherwise increments.
- Divisor by `cur_sel`:
  - 0 RCFAST → DIV_RCFAST; 1 RCSLOW → DIV_RCSLOW.
  - 2 XINPUT → 16; 3 XTAL1 → 16; 4 XTAL2 → 8; 5 XTAL4 → 4; 6 XTAL8 → 2; 7 XTAL16 → 1.
  - Divide-by-1: `ena_cog` is constantly 1.
- Select requirements:
  - Sel 2..7 require `osc_ok`. Sel 4..7 additionally require `pll_ok`.
  - Requirement not met: `cur_sel` holds its value and `sel_err` is set.
- Switching:
  - A `cfg[2:0]` different from `cur_sel` is sampled only in the `ena_cog` cycle.
  - If accepted, `cur_sel` updates on that edge and `div_cnt` restarts at 0.
  - The final old period and the first new period are both complete; no short or merged periods.
- Stabilisation counters:
  - `osc_cnt` counts while `cfg[5]`=1 and saturates at OSC_WAIT, setting `osc_ok`.
  - `cfg[5]`=0 clears `osc_cnt` and `osc_ok` in the same cycle.
  - `pll_cnt` behaves the same, gated by `cfg[6] & osc_ok`, with PLL_WAIT setting `pll_ok`.
- Loss of source: if the `ok` flag required by `cur_sel` drops, `cur_sel` becomes 0 and `div_cnt`=0 immediately, without waiting for a strobe.
  - This is the only asynchronous-to-period switch; one short period is allowed here.
- Simultaneous events:
  - Loss of source beats a pending select.
  - `cfg[7]` beats everything in RUN.
  - `nres` beats all.
- Mid-operation `nres` assertion restores all reset values immediately.
- Width rules:
  - All counters saturate or wrap exactly as stated; no overflow beyond the parameter widths.
  - `div_cnt` width = clog2(max divisor).

Decomposition:
- Shared package `p1v_clk_pkg`:
  - CLKSEL enum (RCFAST, RCSLOW, XINPUT, XTAL1, XTAL2, XTAL4, XTAL8, XTAL16).
  - cfg bit-index constants.
  - FSM state typedef.
  - Divisor lookup function.
- One sub-module `stab_cnt`: enable-gated saturating counter with a `done` flag, parameterised by wait length. It is instanced twice (oscillator and PLL).

Test Plan:
- Release `nres`, `cfg`=0 → `inp_res`=1 for exactly 64 cycles; `ena_cog` period 16 from the first cycle; `cur_sel`=0.
- `cfg`=8'h22 (OSCENA, XINPUT) at cycle 100 → `sel_err`=1 and `cur_sel` stays 0 until cycle 100+1024. At the first subsequent `ena_cog`, `cur_sel`=2 and `sel_err` clears.
- `cfg`=8'h6F (PLLENA, OSCENA, XTAL16) from reset → `cur_sel` reaches 7 after OSC_WAIT+PLL_WAIT plus strobe alignment; then `ena_cog` is constantly 1.
- In XTAL4 (period 4), drop `cfg[6]` → `pll_ok`=0 and `cur_sel`=0 in the same cycle; next strobe after 16 cycles.
- Switch 1→0 requested mid-period with `div_cnt`=2000 → old period completes at 4096, then 16-cycle periods follow; no strobe lost or duplicated.
- In RUN set `cfg[7]`=1 for 3 cycles → `inp_res` rises next cycle and stays high until 64 cycles after `cfg[7]` clears; `cur_sel`=0.
